peripheral_showresult: RTL and testbench

- Output-side peripheral directly downstream of operand capture and the ALU.
- Latches one 32-bit result plus 4 ALU flags, then steps it out one byte at a time on an 8-bit board output (LEDs/display), least significant byte first.
- The user advances each byte with the same enter button used for operand entry; a final flags byte follows the result bytes.
- Asserts done when the sequence ends and returns to idle, ready for the next result.

---
 rtl/peripheral_pkg.sv | 17 +
 rtl/peripheral_edgedetect.sv | 23 ++
 rtl/peripheral_showresult.sv | 114 +++++++++++
 tb/tb_peripheral_showresult.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/peripheral_pkg.sv
// Shared types and constants for the result display peripheral.
package peripheral_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHOW,
    S_FLAGS
  } state_t;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  localparam int NBYTES_DEF = 4;

endpackage

// File: rtl/peripheral_edgedetect.sv
// Rising-edge strobe from the raw enter level; strobe is combinational off the registered history.
// Latency: same cycle as the rising level; no backpressure.
module peripheral_edgedetect (
  input  logic clk,
  input  logic reset,
  input  logic enterpulse,
  output logic adv
);

  logic enterpulse_q;

  // History clears to 0, so a button already held at reset release counts as a press.
  always_ff @(posedge clk) begin
    if (reset) begin
      enterpulse_q <= 1'b0;
    end else begin
      enterpulse_q <= enterpulse;
    end
  end

  assign adv = enterpulse & ~enterpulse_q;

endmodule

// File: rtl/peripheral_showresult.sv
// Latches an ALU result and flags, then steps them out one byte per enter press, LSB first, flags last.
// Latency: 1 clk from result_valid/press to outputs; result_valid is dropped while busy (upstream waits on busy=0).
module peripheral_showresult
  import peripheral_pkg::*;
#(
  parameter int NBYTES = NBYTES_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enterpulse,
  input  logic                  result_valid,
  input  logic [NBYTES*8-1:0]   result,
  input  logic [3:0]            flags,
  output logic [7:0]            outputdata,
  output logic [3:0]            dataoutput_i,
  output logic                  busy,
  output logic                  done
);

  if (NBYTES < 1 || NBYTES > 15) begin : g_nbytes_check
    $error("peripheral_showresult: NBYTES must be in 1..15");
  end

  localparam logic [3:0] LAST_IDX = 4'(NBYTES - 1);
  localparam logic [3:0] FLAG_IDX = 4'(NBYTES);

  logic                adv;
  state_t              state, state_n;
  logic [NBYTES*8-1:0] res_q, res_n;
  logic [3:0]          flags_q, flags_n;
  logic [7:0]          out_n;
  logic [3:0]          idx_n;
  logic                busy_n;
  logic                done_n;
  logic [7:0]          flag_byte;

  peripheral_edgedetect u_edgedetect (
    .clk        (clk),
    .reset      (reset),
    .enterpulse (enterpulse),
    .adv        (adv)
  );

  assign flag_byte = {4'b0000, flags_q[FLAG_N], flags_q[FLAG_Z],
                      flags_q[FLAG_C], flags_q[FLAG_V]};

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_IDLE;
      res_q        <= '0;
      flags_q      <= '0;
      outputdata   <= '0;
      dataoutput_i <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      state        <= state_n;
      res_q        <= res_n;
      flags_q      <= flags_n;
      outputdata   <= out_n;
      dataoutput_i <= idx_n;
      busy         <= busy_n;
      done         <= done_n;
    end
  end

  // Outputs hold unless a capture or a valid advance happens; done is a single-cycle pulse.
  always_comb begin
    state_n = state;
    res_n   = res_q;
    flags_n = flags_q;
    out_n   = outputdata;
    idx_n   = dataoutput_i;
    busy_n  = busy;
    done_n  = 1'b0;
    case (state)
      S_IDLE: begin
        if (result_valid) begin
          res_n   = result;
          flags_n = flags;
          state_n = S_SHOW;
          out_n   = result[7:0];
          idx_n   = 4'd0;
          busy_n  = 1'b1;
        end
      end
      S_SHOW: begin
        if (adv) begin
          if (dataoutput_i == LAST_IDX) begin
            state_n = S_FLAGS;
            out_n   = flag_byte;
            idx_n   = FLAG_IDX;
          end else begin
            idx_n = dataoutput_i + 4'd1;
            out_n = res_q[{idx_n, 3'b000} +: 8];
          end
        end
      end
      S_FLAGS: begin
        if (adv) begin
          state_n = S_IDLE;
          out_n   = 8'h00;
          idx_n   = 4'd0;
          busy_n  = 1'b0;
          done_n  = 1'b1;
        end
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_peripheral_showresult.sv
// Randomized and directed bench for peripheral_showresult against a byte-list reference model.
module tb_peripheral_showresult;

  localparam int NB = 4;

  logic            clk = 1'b0;
  logic            reset;
  logic            enterpulse;
  logic            result_valid;
  logic [NB*8-1:0] result;
  logic [3:0]      flags;
  logic [7:0]      outputdata;
  logic [3:0]      dataoutput_i;
  logic            busy;
  logic            done;

  int checks = 0;
  int passed = 0;

  peripheral_showresult #(.NBYTES(NB)) dut (
    .clk          (clk),
    .reset        (reset),
    .enterpulse   (enterpulse),
    .result_valid (result_valid),
    .result       (result),
    .flags        (flags),
    .outputdata   (outputdata),
    .dataoutput_i (dataoutput_i),
    .busy         (busy),
    .done         (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Reference model: a list of bytes to show and a cursor into it.
  logic [7:0] m_bytes [NB+1];
  bit         m_active = 0;
  bit         m_done   = 0;
  bit         m_prev   = 0;
  bit         m_valid  = 0;
  int         m_pos    = 0;

  always @(posedge clk) begin
    bit press;
    if (reset) begin
      m_valid  = 1;
      m_active = 0;
      m_done   = 0;
      m_prev   = 0;
      m_pos    = 0;
    end else begin
      press    = enterpulse && !m_prev;
      m_prev   = enterpulse;
      m_done   = 0;
      if (!m_active) begin
        if (result_valid) begin
          for (int i = 0; i < NB; i++) m_bytes[i] = result[8*i +: 8];
          m_bytes[NB] = {4'b0000, flags};
          m_active = 1;
          m_pos    = 0;
        end
      end else if (press) begin
        if (m_pos == NB) begin
          m_active = 0;
          m_done   = 1;
          m_pos    = 0;
        end else begin
          m_pos++;
        end
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (m_valid) begin
      check("cyc_outputdata", outputdata, m_active ? m_bytes[m_pos] : 8'h00);
      check("cyc_index", dataoutput_i, m_active ? m_pos : 0);
      check("cyc_busy", busy, m_active);
      check("cyc_done", done, m_done);
    end
  end

  task automatic load(input logic [31:0] r, input logic [3:0] f);
    result       = r;
    flags        = f;
    result_valid = 1'b1;
    @(negedge clk);
    result_valid = 1'b0;
    result       = $urandom;
    flags        = 4'($urandom);
  endtask

  task automatic press_chk(input string name, input logic [7:0] eout, input logic [3:0] eidx);
    enterpulse = 1'b1;
    @(negedge clk);
    enterpulse = 1'b0;
    check({name, "_out"}, outputdata, eout);
    check({name, "_idx"}, dataoutput_i, eidx);
    @(negedge clk);
  endtask

  task automatic press();
    enterpulse = 1'b1;
    @(negedge clk);
    enterpulse = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    reset        = 1'b1;
    enterpulse   = 1'($urandom);
    result_valid = 1'($urandom);
    result       = $urandom;
    flags        = 4'($urandom);
    @(negedge clk);
    enterpulse   = 1'($urandom);
    result_valid = 1'($urandom);
    result       = $urandom;
    @(negedge clk);
    check("rst_out", outputdata, 8'h00);
    check("rst_idx", dataoutput_i, 4'd0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    enterpulse   = 1'b0;
    result_valid = 1'b0;
    reset        = 1'b0;
    @(negedge clk);

    // Full sequence
    load(32'h12345678, 4'b0101);
    check("load_out", outputdata, 8'h78);
    check("load_idx", dataoutput_i, 4'd0);
    check("load_busy", busy, 1'b1);
    press_chk("seq1", 8'h56, 4'd1);
    press_chk("seq2", 8'h34, 4'd2);
    press_chk("seq3", 8'h12, 4'd3);
    press_chk("seqf", 8'h05, 4'd4);
    enterpulse = 1'b1;
    @(negedge clk);
    enterpulse = 1'b0;
    check("end_done", done, 1'b1);
    check("end_busy", busy, 1'b0);
    check("end_out", outputdata, 8'h00);
    @(negedge clk);
    check("end_done_drop", done, 1'b0);

    // Held button advances once
    load(32'h12345678, 4'b0101);
    enterpulse = 1'b1;
    repeat (10) @(negedge clk);
    check("held_idx", dataoutput_i, 4'd1);
    check("held_out", outputdata, 8'h56);
    enterpulse = 1'b0;
    @(negedge clk);
    check("held_rel_idx", dataoutput_i, 4'd1);

    // result_valid while busy is ignored
    result       = 32'hDEADBEEF;
    result_valid = 1'b1;
    @(negedge clk);
    result_valid = 1'b0;
    check("busy_ign_out", outputdata, 8'h56);
    press_chk("busy2", 8'h34, 4'd2);
    press_chk("busy3", 8'h12, 4'd3);
    press_chk("busyf", 8'h05, 4'd4);
    result       = 32'hCAFEF00D;
    result_valid = 1'b1;
    enterpulse   = 1'b1;
    @(negedge clk);
    enterpulse   = 1'b0;
    result_valid = 1'b0;
    check("final_rv_busy", busy, 1'b0);
    check("final_rv_done", done, 1'b1);
    load(32'hA5A5A5C3, 4'hF);
    check("after_done_out", outputdata, 8'hC3);
    check("after_done_busy", busy, 1'b1);
    repeat (5) press();
    check("after_done_idle", busy, 1'b0);

    // Mid-sequence reset
    load(32'h12345678, 4'b0101);
    press_chk("mid1", 8'h56, 4'd1);
    press_chk("mid2", 8'h34, 4'd2);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("mid_rst_out", outputdata, 8'h00);
    check("mid_rst_idx", dataoutput_i, 4'd0);
    check("mid_rst_busy", busy, 1'b0);
    load(32'h000000FF, 4'h0);
    check("mid_new_out", outputdata, 8'hFF);
    check("mid_new_idx", dataoutput_i, 4'd0);
    repeat (5) press();

    // Presses in idle do nothing
    for (int i = 0; i < 4; i++) begin
      enterpulse = 1'b1;
      @(negedge clk);
      enterpulse = 1'b0;
      check("idle_busy", busy, 1'b0);
      check("idle_out", outputdata, 8'h00);
      check("idle_done", done, 1'b0);
      @(negedge clk);
    end

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      reset        = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 2) == 0) enterpulse = ~enterpulse;
      result_valid = ($urandom_range(0, 9) == 0);
      result       = $urandom;
      flags        = 4'($urandom);
    end
    reset = 1'b0;
    @(negedge clk);
    @(negedge clk);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
